// File: rtl/fifo_write_ctrl.sv
// Writer-side FIFO flow control: a two-entry skid buffer that drains into the FIFO write port.
// Optional stall statistics counter is built only when WRITE_STALL_STATS_EN is defined.
module fifo_write_ctrl #(
    parameter int BITNUMBER = 6,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [BITNUMBER-1:0] in_data,
    output logic                 in_ready,
    input  logic                 pause,
    input  logic                 Fifo_full,
    output logic                 Fifo_wr,
    output logic [BITNUMBER-1:0] Fifo_data_in,
    output logic [CNT_W-1:0]     stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t               state;
    state_t               next_state;
    logic [BITNUMBER-1:0] head;
    logic [BITNUMBER-1:0] tail;
    logic                 accept;
    logic                 pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            EMPTY: begin
                if (accept) begin
                    next_state = ONE;
                end
            end
            ONE: begin
                if (accept && !pop) begin
                    next_state = TWO;
                end else if (!accept && pop) begin
                    next_state = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    next_state = ONE;
                end
            end
            default: next_state = EMPTY;
        endcase
    end

    // Outputs are forced quiet while reset is high, even if the buffer still holds words.
    always_comb begin
        in_ready     = 1'b0;
        Fifo_wr      = 1'b0;
        Fifo_data_in = '0;
        if (!reset) begin
            in_ready     = (state != TWO);
            Fifo_wr      = (state != EMPTY) && !pause && !Fifo_full;
            Fifo_data_in = head;
        end
    end

    assign accept = in_valid && in_ready;
    assign pop    = Fifo_wr;

    // Head always holds the oldest word; tail is only used while two words are buffered.
    always_ff @(posedge clk) begin
        if (reset) begin
            head <= '0;
            tail <= '0;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (accept) begin
                        head <= in_data;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        head <= in_data;
                    end else if (accept) begin
                        tail <= in_data;
                    end
                end
                TWO: begin
                    if (pop) begin
                        head <= tail;
                    end
                end
                default: begin
                    head <= head;
                end
            endcase
        end
    end

`ifdef WRITE_STALL_STATS_EN
    logic [CNT_W-1:0] stall_q;

    // Saturating count of cycles a buffered word was held back.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else if ((state != EMPTY) && (pause || Fifo_full) && (stall_q != '1)) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_write_ctrl.sv
// Self-checking bench for fifo_write_ctrl: directed scenarios plus random traffic against a queue model.
// A second instance with a 3-bit stall counter exercises saturation when WRITE_STALL_STATS_EN is defined.
module tb_fifo_write_ctrl;

   localparam int BW  = 6;
   localparam int CW  = 16;
   localparam int CWS = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic [BW-1:0] in_data;
   logic          pause;
   logic          Fifo_full;
   logic          in_ready;
   logic          Fifo_wr;
   logic [BW-1:0] Fifo_data_in;
   logic [CW-1:0] stall_cnt;
   logic          in_ready_s;
   logic          Fifo_wr_s;
   logic [BW-1:0] Fifo_data_in_s;
   logic [CWS-1:0] stall_cnt_s;

   int checkCount = 0;
   int passCount  = 0;

   logic [BW-1:0] modelQ[$];
   logic [BW-1:0] popQ[$];
   logic [BW-1:0] rxQ[$];
   longint        stallRaw = 0;
   logic          acc;

   fifo_write_ctrl #(.BITNUMBER(BW), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .pause(pause), .Fifo_full(Fifo_full),
      .Fifo_wr(Fifo_wr), .Fifo_data_in(Fifo_data_in), .stall_cnt(stall_cnt)
   );

   fifo_write_ctrl #(.BITNUMBER(BW), .CNT_W(CWS)) dutSmall (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready_s), .pause(pause), .Fifo_full(Fifo_full),
      .Fifo_wr(Fifo_wr_s), .Fifo_data_in(Fifo_data_in_s), .stall_cnt(stall_cnt_s)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      if (observed === expected) passCount++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
   endtask

   function automatic logic [63:0] expStall(input int w);
`ifdef WRITE_STALL_STATS_EN
      longint maxVal = (longint'(1) << w) - 1;
      return (stallRaw > maxVal) ? maxVal : stallRaw;
`else
      return (w > 0) ? 64'd0 : 64'd0;
`endif
   endfunction

   // One clock cycle: drive inputs, check outputs against the model, then advance the model.
   task automatic applyStimulus(input logic v, input logic [BW-1:0] d, input logic p, input logic f,
                                output logic accepted);
      logic expReady, expWr;
      @(negedge clk);
      reset = 1'b0; in_valid = v; in_data = d; pause = p; Fifo_full = f;
      #1;
      expReady = (modelQ.size() < 2);
      expWr    = (modelQ.size() > 0) && !p && !f;
      checkOutput("in_ready", in_ready, expReady);
      checkOutput("Fifo_wr", Fifo_wr, expWr);
      checkOutput("Fifo_wr_small", Fifo_wr_s, expWr);
      if (expWr) checkOutput("Fifo_data_in", Fifo_data_in, modelQ[0]);
      checkOutput("stall_cnt", stall_cnt, expStall(CW));
      checkOutput("stall_cnt_small", stall_cnt_s, expStall(CWS));
      if (Fifo_wr === 1'b1) rxQ.push_back(Fifo_data_in);
      @(posedge clk);
      if ((modelQ.size() > 0) && (p || f)) stallRaw++;
      if (expWr) popQ.push_back(modelQ.pop_front());
      accepted = v && expReady;
      if (accepted) modelQ.push_back(d);
   endtask

   task automatic resetDut(input logic p);
      @(negedge clk);
      reset = 1'b1; in_valid = 1'b1; in_data = 6'h3F; pause = p; Fifo_full = 1'b0;
      #1;
      checkOutput("reset_in_ready", in_ready, 1'b0);
      checkOutput("reset_Fifo_wr", Fifo_wr, 1'b0);
      checkOutput("reset_Fifo_data_in", Fifo_data_in, '0);
      @(posedge clk);
      modelQ.delete();
      stallRaw = 0;
   endtask

   task automatic sendWord(input logic [BW-1:0] d, input logic p, input logic f);
      logic a;
      for (int k = 0; k < 20; k++) begin
         applyStimulus(1'b1, d, p, f, a);
         if (a) return;
      end
      checkOutput("accept_timeout", 1'b0, 1'b1);
   endtask

   task automatic idle(input int n, input logic p, input logic f);
      logic a;
      for (int k = 0; k < n; k++) applyStimulus(1'b0, '0, p, f, a);
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_data = '0; pause = 1'b0; Fifo_full = 1'b0;
      resetDut(1'b0);

      // Back-to-back stream with no back-pressure.
      sendWord(6'h01, 1'b0, 1'b0);
      sendWord(6'h02, 1'b0, 1'b0);
      sendWord(6'h03, 1'b0, 1'b0);
      idle(3, 1'b0, 1'b0);

      // Fill both entries under pause, third word waits upstream.
      sendWord(6'h0A, 1'b1, 1'b0);
      sendWord(6'h0B, 1'b1, 1'b0);
      applyStimulus(1'b1, 6'h0C, 1'b1, 1'b0, acc);
      checkOutput("third_word_held", acc, 1'b0);
      sendWord(6'h0C, 1'b0, 1'b0);
      idle(3, 1'b0, 1'b0);

      // Fifo_full alone blocks the write.
      sendWord(6'h15, 1'b0, 1'b1);
      idle(3, 1'b0, 1'b1);
      idle(2, 1'b0, 1'b0);

      // Toggle pause every cycle while streaming 0x00..0x3F.
      begin
         int i = 0;
         int budget = 400;
         logic tog = 1'b0;
         while (i < 64 && budget > 0) begin
            applyStimulus(1'b1, BW'(i), tog, 1'b0, acc);
            tog = ~tog;
            if (acc) i++;
            budget--;
         end
         checkOutput("stream_all_accepted", i, 64);
      end
      idle(4, 1'b0, 1'b0);

      // Reset while two words are buffered; they must never appear.
      sendWord(6'h11, 1'b1, 1'b0);
      sendWord(6'h22, 1'b1, 1'b0);
      resetDut(1'b0);
      idle(4, 1'b0, 1'b0);

      // Stall statistics: 5 paused cycles, then a long pause to saturate the small counter.
      resetDut(1'b0);
      sendWord(6'h05, 1'b1, 1'b0);
      idle(5, 1'b1, 1'b0);
`ifdef WRITE_STALL_STATS_EN
      checkOutput("stall_after_5", stallRaw, 5);
`endif
      idle(10, 1'b1, 1'b0);
      idle(1, 1'b0, 1'b0);

      // Random traffic.
      for (int n = 0; n < 400; n++) begin
         applyStimulus(1'($urandom_range(0, 3) != 0), BW'($urandom), 1'($urandom_range(0, 2) == 0),
                       1'($urandom_range(0, 4) == 0), acc);
      end
      idle(4, 1'b0, 1'b0);

      // Everything the model popped must match what the DUT wrote, in order.
      checkOutput("rx_count", rxQ.size(), popQ.size());
      for (int k = 0; k < rxQ.size() && k < popQ.size(); k++) begin
         if (rxQ[k] !== popQ[k]) checkOutput("rx_order", rxQ[k], popQ[k]);
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
